// File: rtl/imem_stream_loader.sv
// imem_stream_loader: writer side of the core's instruction memory.
// Receives a framed byte stream (16-bit LE word count, N little-endian words,
// XOR checksum byte), writes each word to consecutive addresses from 0 and
// keeps the core in cpu_hold until a load finishes with a matching checksum.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a load (honoured in IDLE, DONE, ERR)
//   s_valid/s_data/s_ready byte stream handshake
//   im_we/im_mode/im_addr/im_din  instruction-memory write port
//   words_loaded          words written in the current load
//   cpu_hold/done/error   load status towards the core
module imem_stream_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              im_we,
  output logic              im_mode,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] hdr_count_c;
  logic [1:0]       byte_idx;
  logic [7:0]       csum;
  logic [31:0]      word;
  logic             xfer_c;
  logic             restart_c;

  assign xfer_c      = s_valid && s_ready;
  assign restart_c   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign hdr_count_c = {s_data, n_words[7:0]};
  assign im_din      = word;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = HDR0;
      HDR0:            if (xfer_c) state_nx = HDR1;
      HDR1: begin
        if (xfer_c) begin
          if (hdr_count_c > CNT_W'(DEPTH)) state_nx = ERR;
          else if (hdr_count_c == '0)      state_nx = CSUM;
          else                             state_nx = DATA;
        end
      end
      DATA:  if (xfer_c && (byte_idx == 2'd3)) state_nx = WRITE;
      WRITE: begin
        if ((CNT_W'(words_loaded) + CNT_W'(1)) == n_words) state_nx = CSUM;
        else                                               state_nx = DATA;
      end
      CSUM: if (xfer_c) state_nx = (s_data == csum) ? DONE : ERR;
      default: state_nx = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    s_ready  = 1'b0;
    im_we    = 1'b0;
    im_mode  = 1'b1;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      HDR0, HDR1, DATA, CSUM: s_ready = 1'b1;
      WRITE: begin
        im_we   = 1'b1;
        im_mode = 1'b0;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: header count, word assembly, checksum, address/word counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_words      <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      word         <= '0;
      im_addr      <= '0;
      words_loaded <= '0;
    end else begin
      if (restart_c) begin
        im_addr      <= '0;
        words_loaded <= '0;
        byte_idx     <= '0;
        csum         <= '0;
      end
      if (xfer_c && (state != CSUM)) csum <= csum ^ s_data;
      if (xfer_c && (state == HDR0)) n_words[7:0]  <= s_data;
      if (xfer_c && (state == HDR1)) n_words[15:8] <= s_data;
      if (xfer_c && (state == DATA)) begin
        word[{byte_idx, 3'b000} +: 8] <= s_data;
        byte_idx                      <= byte_idx + 2'd1;
      end
      if (state == WRITE) begin
        im_addr      <= im_addr + ADDR_W'(1);
        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: normal load, bad checksum, oversize
// header, empty load, backpressure with a byte offered during WRITE, and a
// reset landing inside a WRITE cycle followed by a clean reload.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        im_we;
  logic        im_mode;
  logic [4:0]  im_addr;
  logic [31:0] im_din;
  logic [5:0]  words_loaded;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  frame [0:10];
  logic [31:0] wr_data [0:15];
  logic [4:0]  wr_addr [0:15];
  int          wr_cnt = 0;
  int          mode_bad = 0;
  int          wr_base;

  imem_stream_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .im_we(im_we), .im_mode(im_mode), .im_addr(im_addr), .im_din(im_din),
    .words_loaded(words_loaded), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Log every write the memory would see
  always @(posedge clk) begin
    if (im_we) begin
      if (wr_cnt < 16) begin
        wr_data[wr_cnt] <= im_din;
        wr_addr[wr_cnt] <= im_addr;
      end
      if (im_mode !== 1'b0) mode_bad <= mode_bad + 1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("handshake_timeout", 32'(t), 32'd0);
    @(negedge clk);
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gap);
    for (int i = 0; i < n; i++) send_byte(frame[i], gap);
    s_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wcnt"}, 32'(wr_cnt - wr_base), 32'd2);
    check({tag, "_a0"}, 32'(wr_addr[wr_base]), 32'd0);
    check({tag, "_d0"}, wr_data[wr_base], 32'h2009_0005);
    check({tag, "_a1"}, 32'(wr_addr[wr_base + 1]), 32'd1);
    check({tag, "_d1"}, wr_data[wr_base + 1], 32'h8C0A_0000);
  endtask

  initial begin
    frame[0] = 8'h02; frame[1] = 8'h00; frame[2] = 8'h05; frame[3] = 8'h00;
    frame[4] = 8'h09; frame[5] = 8'h20; frame[6] = 8'h00; frame[7] = 8'h00;
    frame[8] = 8'h0A; frame[9] = 8'h8C; frame[10] = 8'hA8;
    reset_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_mode", 32'(im_mode), 32'd1);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_din", im_din, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 32'(s_ready), 32'd0);

    // Normal load
    wr_base = wr_cnt;
    do_start();
    check("hdr0_s_ready", 32'(s_ready), 32'd1);
    send_frame(11, 1'b1);
    check_writes("normal");
    check("normal_words", 32'(words_loaded), 32'd2);
    check("normal_done", 32'(done), 32'd1);
    check("normal_hold", 32'(cpu_hold), 32'd0);
    check("normal_error", 32'(error), 32'd0);
    check("done_s_ready", 32'(s_ready), 32'd0);

    // Bad checksum
    frame[10] = 8'h00;
    wr_base = wr_cnt;
    do_start();
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    send_frame(11, 1'b0);
    @(negedge clk);
    check_writes("badck");
    check("badck_error", 32'(error), 32'd1);
    check("badck_done", 32'(done), 32'd0);
    check("badck_hold", 32'(cpu_hold), 32'd1);
    frame[10] = 8'hA8;

    // Oversize header, N = 33
    wr_base = wr_cnt;
    do_start();
    check("err_clr", 32'(error), 32'd0);
    send_byte(8'h21, 1'b0);
    send_byte(8'h00, 1'b0);
    s_valid = 1'b0;
    check("over_error", 32'(error), 32'd1);
    repeat (3) @(negedge clk);
    check("over_wcnt", 32'(wr_cnt - wr_base), 32'd0);
    check("over_error_held", 32'(error), 32'd1);

    // Empty load
    wr_base = wr_cnt;
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    check("empty_words", 32'(words_loaded), 32'd0);
    check("empty_wcnt", 32'(wr_cnt - wr_base), 32'd0);

    // Backpressure: gaps everywhere, byte offered during the first WRITE
    wr_base = wr_cnt;
    do_start();
    for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b1);
    send_byte(frame[5], 1'b0);
    s_data = frame[6];
    check("bp_write_ready", 32'(s_ready), 32'd0);
    check("bp_write_we", 32'(im_we), 32'd1);
    check("bp_write_mode", 32'(im_mode), 32'd0);
    check("bp_write_addr", 32'(im_addr), 32'd0);
    check("bp_write_din", im_din, 32'h2009_0005);
    for (int i = 6; i < 11; i++) send_byte(frame[i], 1'b1);
    check_writes("bp");
    check("bp_done", 32'(done), 32'd1);
    check("bp_words", 32'(words_loaded), 32'd2);

    // Reset landing inside the first WRITE
    wr_base = wr_cnt;
    do_start();
    for (int i = 0; i < 6; i++) send_byte(frame[i], 1'b0);
    s_valid = 1'b0;
    check("mid_we_before", 32'(im_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_we_after", 32'(im_we), 32'd0);
    check("mid_hold", 32'(cpu_hold), 32'd1);
    check("mid_s_ready", 32'(s_ready), 32'd0);
    check("mid_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_no_write", 32'(wr_cnt - wr_base), 32'd0);
    do_start();
    send_frame(11, 1'b0);
    @(negedge clk);
    check_writes("reload");
    check("reload_done", 32'(done), 32'd1);
    check("write_mode_all", 32'(mode_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Writer side of the instruction memory that the processor core reads through the PC.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses from 0 and checks a trailing XOR checksum.
- Holds the core in `cpu_hold` until a load completes cleanly.

Parameters:
- ADDR_W, 5, instruction-memory address width; matches the 5-bit PC.
- DEPTH, 32, maximum loadable words. Must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load. Sampled in IDLE, DONE and ERR only; ignored elsewhere.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader can accept a byte. A byte transfers on posedge when s_valid && s_ready.
- im_we  out  1  instruction-memory write_enable.
- im_mode  out  1  instruction-memory mode: 0 = write, 1 = read.
- im_addr  out  ADDR_W  instruction-memory address.
- im_din  out  32  instruction-memory data_in.
- words_loaded  out  ADDR_W+1  count of words written in the current load.
- cpu_hold  out  1  high = core must not fetch or execute.
- done  out  1  load finished, checksum matched.
- error  out  1  load aborted (oversize header or checksum mismatch).

Behaviour:
- Frame format, in order:
  - HDR0, HDR1: word count N, 16-bit little-endian.
  - N x 4 payload bytes, each word little-endian (first byte = bits 7:0).
  - One checksum byte = XOR of every preceding frame byte, header bytes included.
- Reset (asynchronous, takes effect immediately):
  - State = IDLE.
  - s_ready=0, im_we=0, im_mode=1, im_addr=0, im_din=0, words_loaded=0.
  - cpu_hold=1, done=0, error=0.
  - Internal byte index, word count and checksum accumulator all 0.
- States: IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: s_ready=0. start -> HDR0; clears im_addr, words_loaded, byte index and checksum.
- HDR0: s_ready=1. On transfer, latch N[7:0], XOR into checksum -> HDR1.
- HDR1: s_ready=1. On transfer, latch N[15:8] and XOR into checksum, then:
  - N > DEPTH -> ERR.
  - N == 0 -> CSUM.
  - otherwise -> DATA.
- DATA: s_ready=1. Each transfer:
  - Byte goes into lane `byte_idx` of the assembly register and is XORed into the checksum.
  - byte_idx increments.
  - On the 4th byte (byte_idx==3): byte_idx wraps to 0 -> WRITE.
- WRITE (exactly one cycle):
  - s_ready=0, im_we=1, im_mode=0.
  - im_din = assembled word, stable for the whole cycle.
  - im_addr = current address.
  - At the end of the cycle: im_addr and words_loaded increment.
  - If words_loaded+1 == N -> CSUM, else -> DATA.
  - Outside WRITE: im_we=0, im_mode=1.
- Throughput: minimum 5 cycles per word (4 byte transfers + 1 WRITE). The first byte after a WRITE can transfer the cycle after WRITE.
- CSUM: s_ready=1. On transfer, byte == accumulator -> DONE, else -> ERR.
- DONE: done=1, cpu_hold=0, s_ready=0. Outputs held. start -> new load (HDR0; done=0, cpu_hold=1 from the next cycle).
- ERR: error=1, cpu_hold=1, s_ready=0.
  - Words already written stay written; there is no rollback.
  - start -> HDR0; error cleared.
- s_valid low while s_ready is high: no state change, partial word retained indefinitely.
- s_data while s_ready is low: ignored, never consumed. The source must hold the byte.
- im_addr never exceeds DEPTH-1 during WRITE; this is guaranteed by the N > DEPTH check.
- Reset during WRITE: im_we drops asynchronously; the partially loaded memory content is not defined by this block.

Test Plan:
- Normal load: start, then bytes 02 00 05 00 09 20 00 00 0A 8C A8.
  - WRITE addr 0 = 0x20090005, then addr 1 = 0x8C0A0000.
  - words_loaded=2, done=1, cpu_hold=0, error=0.
- Bad checksum: same frame with last byte 00.
  - Both writes occur.
  - error=1, done=0, cpu_hold=1.
- Oversize: header 21 00 (N=33).
  - ERR the cycle after the 2nd byte.
  - im_we never asserted, error=1.
- Empty load: 00 00 00.
  - No im_we pulse, done=1, words_loaded=0.
- Backpressure and gaps:
  - s_valid toggled every other cycle, and a byte presented during WRITE.
  - s_ready=0 in WRITE; the byte is taken the following cycle, with no loss or duplication.
  - Resulting memory contents identical to the normal-load scenario.
- Reset mid-load: assert reset_n=0 after the 6th byte of the normal-load frame.
  - im_we=0 and cpu_hold=1 immediately; state IDLE.
  - Re-issuing start with the full frame writes addr 0 and 1 correctly, then done=1.
